// File: rtl/writeback_cycle.sv
// writeback_cycle: EX/MEM/WB register-write path with load extension.
// Optional MEM/WB forwarding ports enabled by WRITEBACK_FORWARD_EN.
module writeback_cycle #(
  parameter int XLEN           = 64,
  parameter int REGISTER_SIZE  = 5,
  parameter int LOAD_TYPE_SIZE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_to_e_enable_ff,
  input  logic                      rf_write_enable,
  input  logic [REGISTER_SIZE-1:0]  rf_write_addr,
  input  logic [1:0]                rf_write_data_sel,
  input  logic                      dm_read_enable,
  input  logic [LOAD_TYPE_SIZE-1:0] dm_load_type,
  input  logic [XLEN-1:0]           PC_in,
  input  logic [XLEN-1:0]           alu_data_out,
  input  logic [XLEN-1:0]           dm_read_data,
  input  logic                      mem_stall,
  output logic                      rf_writeback_enable,
  output logic [REGISTER_SIZE-1:0]  rf_writeback_addr,
  output logic [XLEN-1:0]           rf_writeback_data,
  output logic                      load_pending,
  output logic                      fwd_mem_valid,
  output logic [REGISTER_SIZE-1:0]  fwd_mem_addr,
  output logic [XLEN-1:0]           fwd_mem_data,
  output logic                      fwd_wb_valid,
  output logic [REGISTER_SIZE-1:0]  fwd_wb_addr,
  output logic [XLEN-1:0]           fwd_wb_data
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef struct packed {
    logic                      valid;
    logic                      we;
    logic [REGISTER_SIZE-1:0]  rd;
    logic [1:0]                sel;
    logic                      is_load;
    logic [LOAD_TYPE_SIZE-1:0] lt;
    logic [XLEN-1:0]           val;
  } stage_t;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [REGISTER_SIZE-1:0] rd;
    logic [XLEN-1:0]          val;
  } wb_t;

  stage_t ex_q, mem_q;
  stage_t ex_d, mem_d;
  wb_t    wb_q, wb_d;

  function automatic logic [XLEN-1:0] load_ext(
    input logic [LOAD_TYPE_SIZE-1:0] t,
    input logic [XLEN-1:0]           d
  );
    logic [XLEN-1:0] r;
    r = d;
    case (t[2:0])
      3'b000: r = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001: r = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b010: r = {{(XLEN-32){d[31]}}, d[31:0]};
      3'b100: r = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101: r = {{(XLEN-16){1'b0}}, d[15:0]};
      3'b110: r = {{(XLEN-32){1'b0}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode controls into EX; x0 and "no write" never set we
  always_comb begin
    ex_d         = '0;
    ex_d.valid   = d_to_e_enable_ff;
    ex_d.we      = rf_write_enable
                 && (rf_write_data_sel != SEL_NONE)
                 && (rf_write_addr != '0);
    ex_d.rd      = rf_write_addr;
    ex_d.sel     = rf_write_data_sel;
    ex_d.is_load = dm_read_enable;
    ex_d.lt      = dm_load_type;
    ex_d.val     = PC_in;
  end

  // EX to MEM: pick ALU result or link address
  always_comb begin
    mem_d = ex_q;
    unique case (1'b1)
      ex_q.sel == SEL_PC4: mem_d.val = ex_q.val + XLEN'(4);
      ex_q.sel == SEL_ALU: mem_d.val = alu_data_out;
      default:             mem_d.val = alu_data_out;
    endcase
  end

  // MEM to WB: loads take extended memory data
  always_comb begin
    wb_d       = '0;
    wb_d.valid = mem_q.valid;
    wb_d.we    = mem_q.we;
    wb_d.rd    = mem_q.rd;
    if (mem_q.sel == SEL_LOAD)
      wb_d.val = load_ext(mem_q.lt, dm_read_data);
    else
      wb_d.val = mem_q.val;
  end

  // Pipeline advance; a stall freezes EX/MEM and bubbles WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (mem_stall) begin
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign rf_writeback_enable = wb_q.valid & wb_q.we;
  assign rf_writeback_addr   = wb_q.rd;
  assign rf_writeback_data   = rf_writeback_enable ? wb_q.val : '0;

  assign load_pending = (ex_q.valid & ex_q.is_load)
                      | (mem_q.valid & mem_q.is_load);

`ifdef WRITEBACK_FORWARD_EN
  assign fwd_mem_valid = mem_q.valid & mem_q.we & ~mem_q.is_load;
  assign fwd_mem_addr  = mem_q.rd;
  assign fwd_mem_data  = mem_q.val;
  assign fwd_wb_valid  = rf_writeback_enable;
  assign fwd_wb_addr   = wb_q.rd;
  assign fwd_wb_data   = rf_writeback_data;
`else
  assign fwd_mem_valid = 1'b0;
  assign fwd_mem_addr  = '0;
  assign fwd_mem_data  = '0;
  assign fwd_wb_valid  = 1'b0;
  assign fwd_wb_addr   = '0;
  assign fwd_wb_data   = '0;
`endif

endmodule
